// File: rtl/ep2_frame_parser_pkg.sv
// ============================================================================
// Module      : ep2_frame_parser_pkg
// Description : Shared constants and state encoding for the HPSDR protocol-1
//               Rx frame parser (ep2_frame_parser and ep2_sample_unpack).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ep2_frame_parser_pkg;

    // Frame layout: 3 sync bytes, 5 C&C bytes, then 8-byte samples
    localparam logic [7:0] SYNC_BYTE    = 8'h7F;
    localparam int         FRAME_BYTES  = 512;
    localparam int         CC_BYTES     = 5;
    localparam int         SAMPLE_BYTES = 8;

    // Parser state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_HUNT  = 3'd0;
    localparam state_t ST_SYNC1 = 3'd1;
    localparam state_t ST_SYNC2 = 3'd2;
    localparam state_t ST_CC    = 3'd3;
    localparam state_t ST_SAMP  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ep2_sample_unpack.sv
// ============================================================================
// Module      : ep2_sample_unpack
// Description : Collects the eight bytes of one sample (Lhi Llo Rhi Rlo Ihi
//               Ilo Qhi Qlo) and presents them as four 16-bit fields with a
//               one-cycle valid pulse after the final byte is accepted.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_shift_en        - accept i_byte this cycle
//               i_clear           - restart at byte 0 (takes priority)
//               i_byte            - incoming sample byte
//               o_last_byte       - current byte position is the final one
//               o_iq_valid        - pulse: sample fields updated
//               o_audio_l/r       - audio fields
//               o_tx_i/q          - transmit I/Q fields
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ep2_sample_unpack
    import ep2_frame_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_shift_en,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_iq_valid,
    output logic [15:0] o_audio_l,
    output logic [15:0] o_audio_r,
    output logic [15:0] o_tx_i,
    output logic [15:0] o_tx_q
);

    localparam int                 c_IDX_W    = $clog2(SAMPLE_BYTES);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(SAMPLE_BYTES - 1);
    localparam int                 c_SHIFT_W  = 8 * (SAMPLE_BYTES - 1);

    logic [c_IDX_W-1:0]   r_byte_idx;
    logic [c_SHIFT_W-1:0] r_shift;
    logic                 r_iq_valid;
    logic [15:0]          r_audio_l;
    logic [15:0]          r_audio_r;
    logic [15:0]          r_tx_i;
    logic [15:0]          r_tx_q;

    assign o_last_byte = (r_byte_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_iq_valid <= 1'b0;
            r_audio_l  <= '0;
            r_audio_r  <= '0;
            r_tx_i     <= '0;
            r_tx_q     <= '0;
        end else begin
            r_iq_valid <= 1'b0;
            if (i_clear) begin
                r_byte_idx <= '0;
            end else if (i_shift_en) begin
                if (o_last_byte) begin
                    // The first seven bytes sit in the shift register; the
                    // eighth comes straight from the input. Stale shift
                    // contents are pushed out over the next sample.
                    r_byte_idx <= '0;
                    {r_audio_l, r_audio_r, r_tx_i, r_tx_q} <= {r_shift, i_byte};
                    r_iq_valid <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_shift    <= {r_shift[c_SHIFT_W-9:0], i_byte};
                end
            end
        end
    end

    assign o_iq_valid = r_iq_valid;
    assign o_audio_l  = r_audio_l;
    assign o_audio_r  = r_audio_r;
    assign o_tx_i     = r_tx_i;
    assign o_tx_q     = r_tx_q;

endmodule

`default_nettype wire

// File: rtl/ep2_frame_parser.sv
// ============================================================================
// Module      : ep2_frame_parser
// Description : Parses HPSDR protocol-1 512-byte frames from the Rx FIFO byte
//               stream. Hunts for three sync bytes, decodes the five C&C
//               bytes into one control word per frame, unpacks the following
//               sample bytes, and tracks sync lock plus a saturating count of
//               sync mismatches. No backpressure: output pulses must be taken.
// Ports       : rx_clk       - byte clock
//               IF_rst_i     - synchronous active-high reset
//               rx_enable_i  - byte strobe
//               rx_data_i    - frame byte
//               cc_valid_o   - pulse: cc_addr_o/cc_ptt_o/cc_data_o updated
//               cc_addr_o    - C0[7:1]
//               cc_ptt_o     - C0[0]
//               cc_data_o    - {C1,C2,C3,C4}
//               iq_valid_o   - pulse: sample fields updated
//               audio_l_o/audio_r_o/tx_i_o/tx_q_o - sample fields
//               locked_o     - frame sync held
//               sync_err_o   - saturating sync-mismatch count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ep2_frame_parser #(
    parameter logic [7:0] SYNC_BYTE         = ep2_frame_parser_pkg::SYNC_BYTE,
    parameter int         SAMPLES_PER_FRAME = 63,
    parameter int         ERR_W             = 8
) (
    input  logic             rx_clk,
    input  logic             IF_rst_i,
    input  logic             rx_enable_i,
    input  logic [7:0]       rx_data_i,
    output logic             cc_valid_o,
    output logic [6:0]       cc_addr_o,
    output logic             cc_ptt_o,
    output logic [31:0]      cc_data_o,
    output logic             iq_valid_o,
    output logic [15:0]      audio_l_o,
    output logic [15:0]      audio_r_o,
    output logic [15:0]      tx_i_o,
    output logic [15:0]      tx_q_o,
    output logic             locked_o,
    output logic [ERR_W-1:0] sync_err_o
);

    import ep2_frame_parser_pkg::*;

    localparam int                  c_SAMP_W  = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [2:0]          c_CC_LAST   = 3'(CC_BYTES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cc_idx;
    logic [c_SAMP_W-1:0] r_samp_idx;
    logic [7:0]          r_c0;
    logic [7:0]          r_c1;
    logic [7:0]          r_c2;
    logic [7:0]          r_c3;
    logic                r_cc_valid;
    logic [6:0]          r_cc_addr;
    logic                r_cc_ptt;
    logic [31:0]         r_cc_data;
    logic                r_locked;
    logic [ERR_W-1:0]    r_sync_err;

    // FSM-decoded control strobes
    logic w_is_sync;
    logic w_err_inc;
    logic w_lock_clr;
    logic w_cc_idx_clr;
    logic w_cc_capture;
    logic w_cc_done;
    logic w_samp_shift;
    logic w_last_byte;

    assign w_is_sync = (rx_data_i == SYNC_BYTE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge rx_clk) begin
        if (IF_rst_i) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (everything holds while rx_enable_i is low)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (rx_enable_i) begin
            case (r_state)
                ST_HUNT:  if (w_is_sync) w_state_nxt = ST_SYNC1;
                ST_SYNC1: w_state_nxt = w_is_sync ? ST_SYNC2 : ST_HUNT;
                ST_SYNC2: w_state_nxt = w_is_sync ? ST_CC : ST_HUNT;
                ST_CC:    if (r_cc_idx == c_CC_LAST) w_state_nxt = ST_SAMP;
                ST_SAMP:  if (w_last_byte && (r_samp_idx == c_SAMP_LAST)) w_state_nxt = ST_HUNT;
                default:  w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_err_inc    = 1'b0;
        w_lock_clr   = 1'b0;
        w_cc_idx_clr = 1'b0;
        w_cc_capture = 1'b0;
        w_cc_done    = 1'b0;
        w_samp_shift = 1'b0;
        if (rx_enable_i) begin
            case (r_state)
                ST_HUNT: begin
                    // Only the first stray byte after losing sync is counted
                    if (!w_is_sync && r_locked) begin
                        w_err_inc  = 1'b1;
                        w_lock_clr = 1'b1;
                    end
                end
                ST_SYNC1: begin
                    if (!w_is_sync && r_locked) begin
                        w_err_inc = 1'b1;
                    end
                end
                ST_SYNC2: begin
                    // Two sync bytes already seen: a mismatch here always counts
                    if (w_is_sync) begin
                        w_cc_idx_clr = 1'b1;
                    end else begin
                        w_err_inc  = 1'b1;
                        w_lock_clr = 1'b1;
                    end
                end
                ST_CC: begin
                    w_cc_capture = 1'b1;
                    w_cc_done    = (r_cc_idx == c_CC_LAST);
                end
                ST_SAMP: begin
                    w_samp_shift = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // C&C capture, frame counters, lock and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge rx_clk) begin
        if (IF_rst_i) begin
            r_cc_idx   <= '0;
            r_samp_idx <= '0;
            r_c0       <= '0;
            r_c1       <= '0;
            r_c2       <= '0;
            r_c3       <= '0;
            r_cc_valid <= 1'b0;
            r_cc_addr  <= '0;
            r_cc_ptt   <= 1'b0;
            r_cc_data  <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= '0;
        end else begin
            r_cc_valid <= w_cc_done;

            if (w_cc_idx_clr) begin
                r_cc_idx <= '0;
            end else if (w_cc_capture) begin
                r_cc_idx <= r_cc_idx + 1'b1;
            end

            if (w_cc_capture) begin
                case (r_cc_idx)
                    3'd0:    r_c0 <= rx_data_i;
                    3'd1:    r_c1 <= rx_data_i;
                    3'd2:    r_c2 <= rx_data_i;
                    3'd3:    r_c3 <= rx_data_i;
                    default: begin
                    end
                endcase
            end

            // C4 is taken directly from the input so the whole word updates
            // on the edge that accepts it.
            if (w_cc_done) begin
                r_cc_addr <= r_c0[7:1];
                r_cc_ptt  <= r_c0[0];
                r_cc_data <= {r_c1, r_c2, r_c3, rx_data_i};
            end

            if (w_cc_done) begin
                r_samp_idx <= '0;
            end else if (w_samp_shift && w_last_byte) begin
                r_samp_idx <= r_samp_idx + 1'b1;
            end

            if (w_cc_done) begin
                r_locked <= 1'b1;
            end else if (w_lock_clr) begin
                r_locked <= 1'b0;
            end

            if (w_err_inc && (r_sync_err != {ERR_W{1'b1}})) begin
                r_sync_err <= r_sync_err + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample unpacker; restarted at byte 0 as each frame's C&C completes
    // ------------------------------------------------------------------
    ep2_sample_unpack u_sample_unpack (
        .clk         (rx_clk),
        .rst         (IF_rst_i),
        .i_shift_en  (w_samp_shift),
        .i_clear     (w_cc_done),
        .i_byte      (rx_data_i),
        .o_last_byte (w_last_byte),
        .o_iq_valid  (iq_valid_o),
        .o_audio_l   (audio_l_o),
        .o_audio_r   (audio_r_o),
        .o_tx_i      (tx_i_o),
        .o_tx_q      (tx_q_o)
    );

    assign cc_valid_o = r_cc_valid;
    assign cc_addr_o  = r_cc_addr;
    assign cc_ptt_o   = r_cc_ptt;
    assign cc_data_o  = r_cc_data;
    assign locked_o   = r_locked;
    assign sync_err_o = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_ep2_frame_parser.sv
// ============================================================================
// Module      : tb_ep2_frame_parser
// Description : Self-checking bench for ep2_frame_parser. A positional frame
//               model predicts C&C words and samples into queues; a monitor
//               pops and compares whenever the DUT pulses a valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ep2_frame_parser;

    localparam int c_ERR_W     = 8;
    localparam int c_SPF       = 63;
    localparam int c_FRAME_LEN = 8 + 8 * c_SPF;
    localparam int c_ERR_MAX   = (1 << c_ERR_W) - 1;

    logic               rx_clk = 1'b0;
    logic               IF_rst_i;
    logic               rx_enable_i;
    logic [7:0]         rx_data_i;
    logic               cc_valid_o;
    logic [6:0]         cc_addr_o;
    logic               cc_ptt_o;
    logic [31:0]        cc_data_o;
    logic               iq_valid_o;
    logic [15:0]        audio_l_o;
    logic [15:0]        audio_r_o;
    logic [15:0]        tx_i_o;
    logic [15:0]        tx_q_o;
    logic               locked_o;
    logic [c_ERR_W-1:0] sync_err_o;

    always #5 rx_clk = ~rx_clk;

    ep2_frame_parser #(
        .SYNC_BYTE         (8'h7F),
        .SAMPLES_PER_FRAME (c_SPF),
        .ERR_W             (c_ERR_W)
    ) dut (
        .rx_clk      (rx_clk),
        .IF_rst_i    (IF_rst_i),
        .rx_enable_i (rx_enable_i),
        .rx_data_i   (rx_data_i),
        .cc_valid_o  (cc_valid_o),
        .cc_addr_o   (cc_addr_o),
        .cc_ptt_o    (cc_ptt_o),
        .cc_data_o   (cc_data_o),
        .iq_valid_o  (iq_valid_o),
        .audio_l_o   (audio_l_o),
        .audio_r_o   (audio_r_o),
        .tx_i_o      (tx_i_o),
        .tx_q_o      (tx_q_o),
        .locked_o    (locked_o),
        .sync_err_o  (sync_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] q_cc[$];
    logic [63:0] q_iq[$];

    // Reference model: position within the frame rather than parser states
    bit         m_in_frame;
    int         m_nsync;
    int         m_pos;
    logic [7:0] m_buf[0:c_FRAME_LEN-1];
    bit         m_locked;
    int         m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 0;
        m_nsync    = 0;
        m_pos      = 0;
        m_locked   = 0;
        m_err      = 0;
        q_cc.delete();
        q_iq.delete();
    endfunction

    function automatic void model_err();
        if (m_err < c_ERR_MAX) m_err++;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [63:0] s;
        if (!m_in_frame) begin
            if (b == 8'h7F) begin
                m_nsync++;
                if (m_nsync == 3) begin
                    m_in_frame = 1;
                    m_pos      = 3;
                end
            end else begin
                if (m_nsync == 2) begin
                    model_err();
                    m_locked = 0;
                end else if (m_locked) begin
                    model_err();
                    if (m_nsync == 0) m_locked = 0;
                end
                m_nsync = 0;
            end
        end else begin
            m_buf[m_pos] = b;
            m_pos++;
            if (m_pos == 8) begin
                q_cc.push_back({m_buf[3], m_buf[4], m_buf[5], m_buf[6], m_buf[7]});
                m_locked = 1;
            end else if (m_pos > 8 && ((m_pos - 8) % 8) == 0) begin
                s = '0;
                for (int k = 8; k > 0; k--) s = {s[55:0], m_buf[m_pos-k]};
                q_iq.push_back(s);
            end
            if (m_pos == c_FRAME_LEN) begin
                m_in_frame = 0;
                m_nsync    = 0;
            end
        end
    endfunction

    // Monitor: every valid pulse must match the oldest predicted entry
    always @(negedge rx_clk) begin
        if (cc_valid_o) begin
            if (q_cc.size() == 0) check("cc_unexpected_pulse", 64'(cc_valid_o), 64'(0));
            else check("cc_word", {24'b0, cc_addr_o, cc_ptt_o, cc_data_o}, {24'b0, q_cc.pop_front()});
        end
        if (iq_valid_o) begin
            if (q_iq.size() == 0) check("iq_unexpected_pulse", 64'(iq_valid_o), 64'(0));
            else check("iq_sample", {audio_l_o, audio_r_o, tx_i_o, tx_q_o}, q_iq.pop_front());
        end
    end

    task automatic idle(input int n);
        rx_enable_i = 1'b0;
        repeat (n) begin
            rx_data_i = 8'($urandom);
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(5, 1)));
        rx_enable_i = 1'b1;
        rx_data_i   = b;
        model_byte(b);
        @(posedge rx_clk);
        #1;
        rx_enable_i = 1'b0;
    endtask

    // Sends the first n_bytes of a frame; sample byte k is k[7:0] unless rnd
    task automatic send_frame(input logic [39:0] cc, input bit rnd, input int gap_pct, input int n_bytes);
        for (int i = 0; i < n_bytes; i++) begin
            logic [7:0] b;
            if (i < 3)      b = 8'h7F;
            else if (i < 8) b = cc[8*(7-i) +: 8];
            else if (rnd)   b = 8'($urandom);
            else            b = 8'(i - 8);
            send_byte(b, gap_pct);
        end
    endtask

    task automatic check_status(input string name);
        check({name, "_locked"},   64'(locked_o),   64'(m_locked));
        check({name, "_sync_err"}, 64'(sync_err_o), 64'(m_err));
    endtask

    task automatic check_zero(input string name);
        check({name, "_cc_valid"}, 64'(cc_valid_o), 64'(0));
        check({name, "_iq_valid"}, 64'(iq_valid_o), 64'(0));
        check({name, "_locked"},   64'(locked_o),   64'(0));
        check({name, "_sync_err"}, 64'(sync_err_o), 64'(0));
        check({name, "_cc"},       {24'b0, cc_addr_o, cc_ptt_o, cc_data_o}, 64'(0));
        check({name, "_samples"},  {audio_l_o, audio_r_o, tx_i_o, tx_q_o}, 64'(0));
    endtask

    localparam logic [39:0] c_CC0 = 40'h03_11223344;

    initial begin
        IF_rst_i    = 1'b1;
        rx_enable_i = 1'b0;
        rx_data_i   = 8'h00;
        model_reset();
        repeat (3) @(posedge rx_clk);
        #1;
        IF_rst_i = 1'b0;
        idle(4);
        check_zero("reset");

        // Clean frame, no gaps
        send_frame(c_CC0, 1'b0, 0, c_FRAME_LEN);
        idle(3);
        check_status("frame1");
        check("frame1_addr",  64'(cc_addr_o), 64'(1));
        check("frame1_ptt",   64'(cc_ptt_o),  64'(1));
        check("frame1_data",  64'(cc_data_o), 64'h11223344);
        check("frame1_lock",  64'(locked_o),  64'(1));
        check("frame1_last_l", 64'(audio_l_o), 64'hF0F1);
        check("frame1_last_q", 64'(tx_q_o),    64'hF6F7);

        // Same frame with random enable gaps
        send_frame(c_CC0, 1'b0, 15, c_FRAME_LEN);
        idle(3);
        check_status("gapframe");
        check("gapframe_data",  64'(cc_data_o), 64'h11223344);
        check("gapframe_last_l", 64'(audio_l_o), 64'hF0F1);

        // Random control words and sample data, with gaps
        for (int f = 0; f < 3; f++) begin
            send_frame({8'($urandom), 32'($urandom)}, 1'b1, 10, c_FRAME_LEN);
            idle(2);
            check_status("randframe");
        end

        // Broken sync after a locked frame
        send_byte(8'h7F, 0);
        send_byte(8'h7F, 0);
        send_byte(8'h00, 0);
        idle(2);
        check("brk_locked",   64'(locked_o),   64'(0));
        check("brk_sync_err", 64'(sync_err_o), 64'(1));
        check_status("brk");

        send_frame(c_CC0, 1'b0, 5, c_FRAME_LEN);
        idle(2);
        check("relock_locked",   64'(locked_o),   64'(1));
        check("relock_sync_err", 64'(sync_err_o), 64'(1));

        // Garbage while locked counts once
        for (int i = 0; i < 300; i++) send_byte(8'h00, 3);
        idle(2);
        check("garbage_sync_err", 64'(sync_err_o), 64'(2));
        check("garbage_locked",   64'(locked_o),   64'(0));

        // Repeated failed re-acquisition saturates the counter
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h7F, 0);
            send_byte(8'h7F, 0);
            send_byte(8'h00, 0);
        end
        idle(2);
        check("sat_sync_err", 64'(sync_err_o), 64'hFF);
        check_status("sat");

        send_frame(c_CC0, 1'b0, 5, c_FRAME_LEN);
        idle(2);
        check_status("satrelock");

        // Reset part-way into sample 30
        send_frame(c_CC0, 1'b0, 10, 8 + 30 * 8 + 3);
        idle(3);
        check("mid_last_l",   64'(audio_l_o), 64'hE8E9);
        check("mid_q_drained", 64'(q_iq.size()), 64'(0));
        IF_rst_i = 1'b1;
        model_reset();
        @(posedge rx_clk);
        #1;
        IF_rst_i = 1'b0;
        idle(3);
        check_zero("midreset");
        for (int i = 8 + 30 * 8 + 3; i < c_FRAME_LEN; i++) send_byte(8'(i - 8), 5);
        idle(3);
        check_status("tail");

        send_frame(c_CC0, 1'b0, 5, c_FRAME_LEN);
        idle(3);
        check_status("postreset");
        check("postreset_data",  64'(cc_data_o), 64'h11223344);
        check("postreset_last_l", 64'(audio_l_o), 64'hF0F1);

        check("end_cc_queue", 64'(q_cc.size()), 64'(0));
        check("end_iq_queue", 64'(q_iq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
